// File: rtl/ucpu_control_sequencer.sv
// ---------------------------------------------------------------------------
// ucpu_control_sequencer
//
// Control stage sitting between instruction memory and the register-file/ALU
// datapath. Fetches one byte-wide instruction at a time over a req/ack
// handshake, decodes it, and sequences the ALU operand loads, register-file
// writeback and PC update (including conditional relative branches).
//
// Ports:
//   sys_clk, sys_reset        clock; synchronous active-high reset
//   imem_req/addr/ack/rdata   instruction fetch handshake (addr = pc)
//   cc_greater, cc_equal      ALU condition codes, sampled by branches
//   cpu_state                 externally visible phase (FETCH..HALT = 0..5)
//   alu_op                    ALU operation, ir[6:4]
//   alu_en_A_reg/B_reg        ALU operand register load enables
//   rf_rsel                   register-file read select for the operand bus
//   rf_we, rf_waddr           register-file writeback
//   pc                        program counter
//   halted                    high while stopped on a HALT instruction
// ---------------------------------------------------------------------------
module ucpu_control_sequencer #(
   parameter int PC_WIDTH    = 5,
   parameter int INSTR_WIDTH = 8
) (
   input  logic                   sys_clk,
   input  logic                   sys_reset,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   input  logic                   cc_greater,
   input  logic                   cc_equal,
   output logic [2:0]             cpu_state,
   output logic [2:0]             alu_op,
   output logic                   alu_en_A_reg,
   output logic                   alu_en_B_reg,
   output logic [1:0]             rf_rsel,
   output logic                   rf_we,
   output logic [1:0]             rf_waddr,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_LDA    = 3'd2,
      S_LDB    = 3'd3,
      S_EXEC2  = 3'd4,
      S_WB     = 3'd5,
      S_BR     = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   // Externally visible cpu_state codes.
   localparam logic [2:0] CS_FETCH     = 3'd0;
   localparam logic [2:0] CS_DECODE    = 3'd1;
   localparam logic [2:0] CS_EXECUTE1  = 3'd2;
   localparam logic [2:0] CS_EXECUTE2  = 3'd3;
   localparam logic [2:0] CS_WRITEBACK = 3'd4;
   localparam logic [2:0] CS_HALT      = 3'd5;

   state_t                 state, state_next;
   logic [PC_WIDTH-1:0]    pc_q, pc_next;
   logic [INSTR_WIDTH-1:0] ir, ir_next;

   logic [1:0]             rd, rs;
   logic signed [4:0]      br_off_raw;
   logic [PC_WIDTH-1:0]    br_offset;
   logic                   br_taken;

   assign rd         = ir[3:2];
   assign rs         = ir[1:0];
   assign br_off_raw = ir[4:0];
   // Sign-extends the 5-bit offset; adding it modulo 2^PC_WIDTH gives the
   // wrapping relative branch from the already-incremented pc.
   assign br_offset  = PC_WIDTH'(br_off_raw);
   // ir[5] separates BGT (1) from BEQ (0).
   assign br_taken   = ir[5] ? cc_greater : cc_equal;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; combinational blocks below use blocking ones.
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state <= S_FETCH;
         pc_q  <= '0;
         ir    <= '0;
      end else begin
         state <= state_next;
         pc_q  <= pc_next;
         ir    <= ir_next;
      end
   end

   // Next-state, PC and IR update.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_next = state;
      pc_next    = pc_q;
      ir_next    = ir;
      case (state)
         S_FETCH: begin
            if (imem_ack) begin
               ir_next    = imem_rdata;
               pc_next    = pc_q + PC_WIDTH'(1);
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!ir[7]) begin
               state_next = S_LDA;
            end else begin
               case (ir[6:5])
                  2'b00, 2'b01: state_next = S_BR;
                  2'b10:        state_next = S_FETCH;
                  default:      state_next = S_HALT;
               endcase
            end
         end
         S_LDA:   state_next = S_LDB;
         S_LDB:   state_next = S_EXEC2;
         S_EXEC2: state_next = S_WB;
         S_WB:    state_next = S_FETCH;
         S_BR: begin
            if (br_taken) pc_next = pc_q + br_offset;
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   // Moore output decode. Strobes are forced low while reset is asserted so
   // no fetch, operand load or writeback leaks out of an aborted instruction.
   always_comb begin
      cpu_state    = CS_FETCH;
      imem_req     = 1'b0;
      alu_en_A_reg = 1'b0;
      alu_en_B_reg = 1'b0;
      rf_rsel      = 2'd0;
      rf_we        = 1'b0;
      halted       = 1'b0;
      case (state)
         S_FETCH: begin
            cpu_state = CS_FETCH;
            imem_req  = 1'b1;
         end
         S_DECODE: cpu_state = CS_DECODE;
         S_LDA: begin
            cpu_state    = CS_EXECUTE1;
            alu_en_A_reg = 1'b1;
            rf_rsel      = rd;
         end
         S_LDB: begin
            cpu_state    = CS_EXECUTE1;
            alu_en_B_reg = 1'b1;
            rf_rsel      = rs;
         end
         S_EXEC2: cpu_state = CS_EXECUTE2;
         S_WB: begin
            cpu_state = CS_WRITEBACK;
            rf_we     = 1'b1;
         end
         S_BR:    cpu_state = CS_EXECUTE1;
         S_HALT: begin
            cpu_state = CS_HALT;
            halted    = 1'b1;
         end
         default: cpu_state = CS_FETCH;
      endcase
      if (sys_reset) begin
         imem_req     = 1'b0;
         alu_en_A_reg = 1'b0;
         alu_en_B_reg = 1'b0;
         rf_we        = 1'b0;
      end
   end

   assign alu_op    = ir[6:4];
   assign rf_waddr  = rd;
   assign pc        = pc_q;
   assign imem_addr = pc_q;

endmodule

// File: tb/tb_ucpu_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ucpu_control_sequencer
//
// Self-checking bench for ucpu_control_sequencer. A vector table covers reset,
// one ALU instruction and a taken BEQ; hand-written sequences cover wait
// states, branch variants, wrap, HALT and reset mid-instruction; a random
// instruction stream is compared against an instruction-level model.
// ---------------------------------------------------------------------------
module tb_ucpu_control_sequencer;

   logic       sys_clk = 1'b0;
   logic       sys_reset;
   logic       imem_req;
   logic [4:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_rdata;
   logic       cc_greater;
   logic       cc_equal;
   logic [2:0] cpu_state;
   logic [2:0] alu_op;
   logic       alu_en_A_reg;
   logic       alu_en_B_reg;
   logic [1:0] rf_rsel;
   logic       rf_we;
   logic [1:0] rf_waddr;
   logic [4:0] pc;
   logic       halted;

   ucpu_control_sequencer #(.PC_WIDTH(5), .INSTR_WIDTH(8)) dut (
      .sys_clk      (sys_clk),
      .sys_reset    (sys_reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .cc_greater   (cc_greater),
      .cc_equal     (cc_equal),
      .cpu_state    (cpu_state),
      .alu_op       (alu_op),
      .alu_en_A_reg (alu_en_A_reg),
      .alu_en_B_reg (alu_en_B_reg),
      .rf_rsel      (rf_rsel),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .pc           (pc),
      .halted       (halted)
   );

   always #5 sys_clk = ~sys_clk;

   int n_pass  = 0;
   int n_total = 0;

   // Model state: program counter and halt flag, tracked per instruction.
   logic [4:0] m_pc;
   logic       m_halted;

   typedef struct {
      logic       rst;
      logic       ack;
      logic [7:0] rdata;
      logic       ceq;
      logic       cgt;
      logic [2:0] cs;
      logic [4:0] pc;
      logic       req;
      logic       ena;
      logic       enb;
      logic [1:0] rsel;
      logic       we;
      logic [1:0] waddr;
      logic       hlt;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [2:0] cs, input logic req,
                             input logic ena, input logic enb, input logic we, input logic hlt);
      check({tag, "_cs"},   32'(cpu_state),    32'(cs));
      check({tag, "_req"},  32'(imem_req),     32'(req));
      check({tag, "_ena"},  32'(alu_en_A_reg), 32'(ena));
      check({tag, "_enb"},  32'(alu_en_B_reg), 32'(enb));
      check({tag, "_we"},   32'(rf_we),        32'(we));
      check({tag, "_hlt"},  32'(halted),       32'(hlt));
      check({tag, "_pc"},   32'(pc),           32'(m_pc));
      check({tag, "_addr"}, 32'(imem_addr),    32'(m_pc));
   endtask

   task automatic do_reset();
      sys_reset  = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 8'($urandom);
      tick();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_strobes", {29'd0, alu_en_A_reg, alu_en_B_reg, rf_we}, 32'd0);
      tick();
      check("rst_cs", 32'(cpu_state), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_strobes2", {29'd0, alu_en_A_reg, alu_en_B_reg, rf_we}, 32'd0);
      sys_reset = 1'b0;
      imem_ack  = 1'b0;
      #1;
      check("post_rst_req", 32'(imem_req), 32'd1);
      check("post_rst_cs", 32'(cpu_state), 32'd0);
      m_pc     = 5'd0;
      m_halted = 1'b0;
   endtask

   // Runs one instruction from FETCH and checks every cycle against the
   // instruction-level model: wait states, decode, then the per-class phases.
   task automatic run_instr(input logic [7:0] instr, input int waits, input logic ceq, input logic cgt);
      logic [1:0] rd;
      logic [1:0] rs;
      int         off;
      rd  = instr[3:2];
      rs  = instr[1:0];
      off = int'($signed(instr[4:0]));
      cc_equal   = 1'($urandom);
      cc_greater = 1'($urandom);
      for (int w = 0; w < waits; w++) begin
         imem_ack   = 1'b0;
         imem_rdata = 8'($urandom);
         tick();
         expect_out("wait", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      imem_ack   = 1'b1;
      imem_rdata = instr;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 8'($urandom);
      m_pc = m_pc + 5'd1;
      expect_out("dec", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (!instr[7]) begin
         tick();
         expect_out("lda", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         check("lda_rsel", 32'(rf_rsel), 32'(rd));
         check("lda_op", 32'(alu_op), 32'(instr[6:4]));
         tick();
         expect_out("ldb", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         check("ldb_rsel", 32'(rf_rsel), 32'(rs));
         check("ldb_op", 32'(alu_op), 32'(instr[6:4]));
         tick();
         expect_out("ex2", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check("ex2_op", 32'(alu_op), 32'(instr[6:4]));
         tick();
         expect_out("wb", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         check("wb_waddr", 32'(rf_waddr), 32'(rd));
         check("wb_op", 32'(alu_op), 32'(instr[6:4]));
         tick();
         expect_out("alu_done", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (instr[6] == 1'b0) begin
         tick();
         expect_out("br", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         cc_equal   = ceq;
         cc_greater = cgt;
         if (instr[5] ? cgt : ceq) m_pc = 5'((int'(m_pc) + off) & 31);
         tick();
         expect_out("br_done", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (instr[5] == 1'b0) begin
         tick();
         expect_out("nop_done", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
         tick();
         expect_out("halt", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         m_halted = 1'b1;
         for (int k = 0; k < 10; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = 8'($urandom);
            cc_equal   = 1'($urandom);
            cc_greater = 1'($urandom);
            tick();
            expect_out("halt_hold", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end
         imem_ack = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] instr;

      sys_reset  = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 8'h00;
      cc_equal   = 1'b0;
      cc_greater = 1'b0;
      m_pc       = 5'd0;
      m_halted   = 1'b0;

      // Reset, ALU 0x16 (op=1 rd=1 rs=2), four NOPs to pc=5, BEQ 0x9D taken.
      //           rst ack rdata  ceq cgt  cs pc req ena enb rsel we waddr hlt
      vecs[0]  = '{1'b1, 1'b1, 8'h16, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 3'd1, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 5'd1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 5'd1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 5'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd1, 5'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 5'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd1, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd1, 5'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 5'd4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd1, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 8'h9D, 1'b0, 1'b0, 3'd1, 5'd6, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 5'd6, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};

      for (int i = 0; i < 19; i++) begin
         sys_reset  = vecs[i].rst;
         imem_ack   = vecs[i].ack;
         imem_rdata = vecs[i].rdata;
         cc_equal   = vecs[i].ceq;
         cc_greater = vecs[i].cgt;
         tick();
         check($sformatf("vec%0d_cs", i),  32'(cpu_state),    32'(vecs[i].cs));
         check($sformatf("vec%0d_pc", i),  32'(pc),           32'(vecs[i].pc));
         check($sformatf("vec%0d_req", i), 32'(imem_req),     32'(vecs[i].req));
         check($sformatf("vec%0d_ena", i), 32'(alu_en_A_reg), 32'(vecs[i].ena));
         check($sformatf("vec%0d_enb", i), 32'(alu_en_B_reg), 32'(vecs[i].enb));
         check($sformatf("vec%0d_we", i),  32'(rf_we),        32'(vecs[i].we));
         check($sformatf("vec%0d_hlt", i), 32'(halted),       32'(vecs[i].hlt));
         if (vecs[i].ena || vecs[i].enb)
            check($sformatf("vec%0d_rsel", i), 32'(rf_rsel), 32'(vecs[i].rsel));
         if (vecs[i].we) begin
            check($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].waddr));
            check($sformatf("vec%0d_op", i), 32'(alu_op), 32'd1);
         end
      end

      // Fetch wait states: three cycles without ack, captured on the fourth.
      do_reset();
      run_instr(8'hC0, 3, 1'b0, 1'b0);
      check("wait_pc", 32'(pc), 32'd1);

      // BEQ 0x9D at pc=5 not taken: pc stays 6.
      do_reset();
      for (int i = 0; i < 5; i++) run_instr(8'hC0, 0, 1'b0, 1'b0);
      run_instr(8'h9D, 0, 1'b0, 1'b1);
      check("beq_nt_pc", 32'(pc), 32'd6);

      // BGT 0xA2 at pc=5 taken: pc = 6 + 2.
      do_reset();
      for (int i = 0; i < 5; i++) run_instr(8'hC0, 0, 1'b0, 1'b0);
      run_instr(8'hA2, 0, 1'b0, 1'b1);
      check("bgt_t_pc", 32'(pc), 32'd8);

      // Backward branch from pc=1 by -2 wraps to 31; NOP at 31 wraps to 0.
      do_reset();
      run_instr(8'h9E, 0, 1'b1, 1'b0);
      check("br_wrap_pc", 32'(pc), 32'd31);
      run_instr(8'hC0, 0, 1'b0, 1'b0);
      check("nop_wrap_pc", 32'(pc), 32'd0);

      // HALT: state 5, halted, no fetch, pc frozen for ten cycles.
      run_instr(8'hE0, 0, 1'b0, 1'b0);
      check("halt_pc", 32'(pc), 32'd1);

      // Reset during S_LDB aborts the instruction with no writeback.
      do_reset();
      imem_ack   = 1'b1;
      imem_rdata = 8'h16;
      tick();
      imem_ack = 1'b0;
      tick();
      tick();
      check("mid_ldb_cs", 32'(cpu_state), 32'd2);
      check("mid_ldb_enb", 32'(alu_en_B_reg), 32'd1);
      sys_reset = 1'b1;
      #1;
      check("mid_rst_enb_gated", 32'(alu_en_B_reg), 32'd0);
      tick();
      check("mid_rst_cs", 32'(cpu_state), 32'd0);
      check("mid_rst_pc", 32'(pc), 32'd0);
      check("mid_rst_we", 32'(rf_we), 32'd0);
      sys_reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("mid_after_we", 32'(rf_we), 32'd0);
         check("mid_after_cs", 32'(cpu_state), 32'd0);
      end

      // Random instruction stream against the model; HALT is kept rare.
      do_reset();
      for (int n = 0; n < 250; n++) begin
         instr = 8'($urandom);
         if (instr[7:5] == 3'b111 && $urandom_range(3) != 0) instr[7:5] = 3'b110;
         run_instr(instr, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
         if (m_halted) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ucpu_control_sequencer.md
Name: ucpu_control_sequencer

Overview:
Upstream control stage for the ALU unit. It fetches 8-bit instructions over a req/ack handshake, decodes them, and drives cpu_state, alu_op and the ALU A/B operand-load enables. It also drives register-file operand select and writeback, and updates the PC, including conditional branches on the ALU condition codes. The block sits between instruction memory and the register file/ALU datapath.

Parameters:
PC_WIDTH, 5, program counter width; PC arithmetic wraps modulo 2^PC_WIDTH
INSTR_WIDTH, 8, instruction width; the encoding below is fixed for 8

Ports:
sys_clk  input  1  system clock, all state updates on rising edge
sys_reset  input  1  synchronous, active-high reset
imem_req  output  1  instruction fetch request
imem_addr  output  PC_WIDTH  fetch address (= pc)
imem_ack  input  1  fetch accepted; imem_rdata valid this cycle
imem_rdata  input  8  instruction byte
cc_greater  input  1  ALU greater flag
cc_equal  input  1  ALU equal flag
cpu_state  output  3  FETCH=0, DECODE=1, EXECUTE1=2, EXECUTE2=3, WRITEBACK=4, HALT=5
alu_op  output  3  ALU operation, = ir[6:4]
alu_en_A_reg  output  1  ALU loads A_bus into A_reg this cycle
alu_en_B_reg  output  1  ALU loads B_bus into B_reg this cycle
rf_rsel  output  2  register file read select driving the operand bus
rf_we  output  1  register file write enable (writes alu_result)
rf_waddr  output  2  register file write address
pc  output  PC_WIDTH  current program counter
halted  output  1  high while in HALT

Behaviour:
- Encoding:
  - ir[7]=0: ALU instruction. alu_op=ir[6:4], rd=ir[3:2], rs=ir[1:0].
  - ir[7:5]=100: BEQ, offset=ir[4:0] signed.
  - ir[7:5]=101: BGT, same offset field.
  - ir[7:5]=110: NOP.
  - ir[7:5]=111: HALT.
- Internal states: S_FETCH, S_DECODE, S_LDA, S_LDB, S_EXEC2, S_WB, S_BR, S_HALT.
- cpu_state mapping:
  - S_FETCH=0, S_DECODE=1.
  - S_LDA, S_LDB and S_BR all map to EXECUTE1=2.
  - S_EXEC2=3, S_WB=4, S_HALT=5.
- All control outputs are combinational decodes of the state register and ir (Moore).
- Reset: sys_reset high at an edge forces the following on the next edge:
  - state S_FETCH, pc=0, ir=0.
  - imem_req, alu_en_A_reg, alu_en_B_reg and rf_we are 0 while sys_reset is high.
  - imem_ack is ignored during reset.
  - Reset applies from any state, including mid-instruction.
- S_FETCH:
  - imem_req=1, held until imem_ack.
  - On the ack cycle: ir<=imem_rdata, pc<=pc+1, go to S_DECODE.
  - Without ack, stay in S_FETCH with pc unchanged (wait states are unbounded).
- S_DECODE (1 cycle):
  - ALU instruction -> S_LDA.
  - BEQ/BGT -> S_BR.
  - NOP -> S_FETCH.
  - HALT -> S_HALT.
- S_LDA: alu_en_A_reg=1, rf_rsel=rd; go to S_LDB.
- S_LDB: alu_en_B_reg=1, rf_rsel=rs; go to S_EXEC2.
- S_EXEC2: no enables asserted; the ALU latches its result; go to S_WB.
- S_WB: rf_we=1, rf_waddr=rd; go to S_FETCH.
- alu_op=ir[6:4] is valid in every state after S_DECODE.
- S_BR:
  - Samples cc_equal (BEQ) or cc_greater (BGT) in this cycle.
  - Taken: pc<=pc+sign_extend(offset), relative to the already-incremented pc, wrapping modulo 2^PC_WIDTH.
  - Not taken: pc unchanged.
  - Either way, go to S_FETCH.
- S_HALT: halted=1, imem_req=0, pc frozen; exits only via reset.
- Latency with zero-wait fetch (ack in the first FETCH cycle):
  - ALU instruction: 6 cycles.
  - Branch: 3 cycles.
  - NOP: 2 cycles.
- pc increment wraps: pc=2^PC_WIDTH-1 increments to 0.

Test Plan:
- Reset: hold sys_reset 2 cycles, then release -> cpu_state=0, pc=0, imem_req=1 in the first post-reset cycle; rf_we=alu_en_A_reg=alu_en_B_reg=0 throughout reset.
- ALU instruction: imem_rdata=0x16 acked immediately. Required response:
  - cpu_state sequence 0,1,2,2,3,4, then 0.
  - alu_en_A_reg with rf_rsel=1 in the first EXECUTE1 cycle.
  - alu_en_B_reg with rf_rsel=2 in the second EXECUTE1 cycle.
  - alu_op=3'b001.
  - rf_we with rf_waddr=1 in WRITEBACK.
  - pc=1.
- Branch: BEQ 0x9D (offset -3) fetched at pc=5. Required response:
  - With cc_equal=1: pc=6 after fetch, then 3 after S_BR.
  - With cc_equal=0: pc stays 6.
  - BGT 0xA2 at pc=5 with cc_greater=1: pc=8.
- Fetch wait states: withhold imem_ack for 3 cycles -> imem_req stays high, cpu_state=0, pc unchanged; ack on the 4th cycle captures the instruction.
- HALT and wrap:
  - 0xE0 -> cpu_state=5, halted=1, imem_req=0, pc frozen for 10 cycles.
  - NOP 0xC0 fetched at pc=31 -> pc=0.
- Reset mid-instruction: assert sys_reset during the S_LDB cycle -> next cycle cpu_state=0, pc=0, no rf_we pulse is ever issued for the aborted instruction.
